gpio_port_pcint: RTL and testbench

Parametrised general-purpose I/O port with an integrated pin-change interrupt unit, the next generation of the fixed 8-bit port blocks. It sits on the core I/O bus (6-bit I/O address, iore/iowe strobes, 8-bit data bus) beside the other peripherals. It drives per-pin pull-up, direction, value and input-enable controls to the pad ring, with per-bit alternate-function overrides. It adds a configurable-depth input synchronizer, a pin-change mask, and a latched interrupt flag with acknowledge.

---
 rtl/gpio_pkg.sv | 24 ++
 rtl/gpio_sync.sv | 25 ++
 rtl/gpio_port_pcint.sv | 164 ++++++++++++++++
 tb/tb_gpio_port_pcint.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO port with pin-change interrupt: default I/O
// addresses, parameter bounds and the warm-up counter state type.
package gpio_pkg;

    localparam logic [5:0] PIN_ADDR_DEF   = 6'h03;
    localparam logic [5:0] DDR_ADDR_DEF   = 6'h04;
    localparam logic [5:0] PORT_ADDR_DEF  = 6'h05;
    localparam logic [5:0] PCMSK_ADDR_DEF = 6'h06;
    localparam logic [5:0] PCIF_ADDR_DEF  = 6'h07;

    localparam int WIDTH_MIN       = 1;
    localparam int WIDTH_MAX       = 8;
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    // Wide enough to hold the deepest synchronizer depth as a countdown value.
    localparam int WARM_CNT_W = $clog2(SYNC_STAGES_MAX + 1);

    typedef enum logic {
        WARMUP = 1'b0,
        ARMED  = 1'b1
    } warm_state_t;

endpackage

// File: rtl/gpio_sync.sv
// WIDTH-bit by STAGES-deep flop-chain synchronizer for asynchronous pad inputs,
// with synchronous active-high clear.
module gpio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] chain_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            chain_reg <= '0;
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], d};
        end
    end

    assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/gpio_port_pcint.sv
// Parametrised GPIO port on the core I/O bus with per-bit pad overrides, input
// synchronizer, pin-change mask and latched pin-change interrupt flag.
module gpio_port_pcint
    import gpio_pkg::*;
#(
    parameter int         WIDTH       = 8,
    parameter int         SYNC_STAGES = 2,
    parameter logic [5:0] PIN_ADDR    = PIN_ADDR_DEF,
    parameter logic [5:0] DDR_ADDR    = DDR_ADDR_DEF,
    parameter logic [5:0] PORT_ADDR   = PORT_ADDR_DEF,
    parameter logic [5:0] PCMSK_ADDR  = PCMSK_ADDR_DEF,
    parameter logic [5:0] PCIF_ADDR   = PCIF_ADDR_DEF
) (
    input  logic             cp2,
    input  logic             ireset,
    input  logic [5:0]       io_addr,
    input  logic             iore,
    input  logic             iowe,
    input  logic [7:0]       dbus_in,
    output logic [7:0]       dbus_out,
    output logic             out_en,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] di_o,
    output logic [WIDTH-1:0] pu_o,
    output logic [WIDTH-1:0] dd_o,
    output logic [WIDTH-1:0] pv_o,
    output logic [WIDTH-1:0] die_o,
    input  logic             pud,
    input  logic             sleep,
    input  logic [WIDTH-1:0] puoe,
    input  logic [WIDTH-1:0] puov,
    input  logic [WIDTH-1:0] ddoe,
    input  logic [WIDTH-1:0] ddov,
    input  logic [WIDTH-1:0] pvoe,
    input  logic [WIDTH-1:0] pvov,
    input  logic [WIDTH-1:0] dieoe,
    input  logic [WIDTH-1:0] dieov,
    input  logic             pcie,
    input  logic             pcint_ack,
    output logic             pcint_irq
);

    // Out-of-range depths are pulled back to the supported window.
    localparam int STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
                            (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX :
                            SYNC_STAGES;

    logic [WIDTH-1:0] ddr_reg;
    logic [WIDTH-1:0] port_reg;
    logic [WIDTH-1:0] pcmsk_reg;
    logic             pcif_reg;
    logic             pcif_next;
    logic [WIDTH-1:0] prev_reg;
    logic [WIDTH-1:0] sync;

    warm_state_t           state_reg, state_next;
    logic [WARM_CNT_W-1:0] cnt_reg, cnt_next;
    logic                  armed;
    logic                  change;

    logic hit_pin, hit_ddr, hit_port, hit_pcmsk, hit_pcif;

    assign hit_pin   = (io_addr == PIN_ADDR);
    assign hit_ddr   = (io_addr == DDR_ADDR);
    assign hit_port  = (io_addr == PORT_ADDR);
    assign hit_pcmsk = (io_addr == PCMSK_ADDR);
    assign hit_pcif  = (io_addr == PCIF_ADDR);

    // Register writes; a PIN write toggles PORT bits under a 1 mask.
    always_ff @(posedge cp2) begin
        if (ireset) begin
            ddr_reg   <= '0;
            port_reg  <= '0;
            pcmsk_reg <= '0;
        end else if (iowe) begin
            if (hit_ddr)   ddr_reg   <= dbus_in[WIDTH-1:0];
            if (hit_port)  port_reg  <= dbus_in[WIDTH-1:0];
            if (hit_pin)   port_reg  <= port_reg ^ dbus_in[WIDTH-1:0];
            if (hit_pcmsk) pcmsk_reg <= dbus_in[WIDTH-1:0];
        end
    end

    always_comb begin
        dbus_out = '0;
        out_en   = iore & (hit_pin | hit_ddr | hit_port | hit_pcmsk | hit_pcif);
        if (iore) begin
            if (hit_pin)   dbus_out[WIDTH-1:0] = di_o;
            if (hit_ddr)   dbus_out[WIDTH-1:0] = ddr_reg;
            if (hit_port)  dbus_out[WIDTH-1:0] = port_reg;
            if (hit_pcmsk) dbus_out[WIDTH-1:0] = pcmsk_reg;
            if (hit_pcif)  dbus_out[0]         = pcif_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_pad
            assign dd_o[gi]  = ddoe[gi]  ? ddov[gi]  : ddr_reg[gi];
            assign pv_o[gi]  = pvoe[gi]  ? pvov[gi]  : port_reg[gi];
            assign pu_o[gi]  = puoe[gi]  ? puov[gi]  : (~ddr_reg[gi] & port_reg[gi] & ~pud);
            assign die_o[gi] = dieoe[gi] ? dieov[gi] : ~sleep;
            assign di_o[gi]  = sync[gi] & die_o[gi];
        end
    endgenerate

    gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) u_sync (
        .clk  (cp2),
        .srst (ireset),
        .d    (pin_i),
        .q    (sync)
    );

    // Warm-up: hold off flag setting while the chain fills from its reset zeros.
    always_ff @(posedge cp2) begin
        if (ireset) begin
            state_reg <= WARMUP;
            cnt_reg   <= WARM_CNT_W'(STAGES);
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        armed      = 1'b0;
        case (state_reg)
            WARMUP: begin
                if (cnt_reg == '0) state_next = ARMED;
                else               cnt_next   = cnt_reg - 1'b1;
            end
            ARMED: armed = 1'b1;
            default: state_next = WARMUP;
        endcase
    end

    // Change detection uses the ungated sync value so it keeps working in sleep.
    assign change = |((sync ^ prev_reg) & pcmsk_reg);

    always_comb begin
        pcif_next = pcif_reg;
        if (change && armed)
            pcif_next = 1'b1;
        else if ((iowe && hit_pcif && dbus_in[0]) || pcint_ack)
            pcif_next = 1'b0;
    end

    always_ff @(posedge cp2) begin
        if (ireset) begin
            prev_reg <= '0;
            pcif_reg <= 1'b0;
        end else begin
            prev_reg <= sync;
            pcif_reg <= pcif_next;
        end
    end

    assign pcint_irq = pcif_reg & pcie;

endmodule

// File: tb/tb_gpio_port_pcint.sv
// Directed bench for gpio_port_pcint (WIDTH=8, SYNC_STAGES=2): bus access,
// pad control muxing, synchronizer latency, pin-change flag and warm-up.
module tb_gpio_port_pcint;

    localparam logic [5:0] A_PIN   = 6'h03;
    localparam logic [5:0] A_DDR   = 6'h04;
    localparam logic [5:0] A_PORT  = 6'h05;
    localparam logic [5:0] A_PCMSK = 6'h06;
    localparam logic [5:0] A_PCIF  = 6'h07;

    logic       cp2 = 1'b0;
    logic       ireset;
    logic [5:0] io_addr;
    logic       iore, iowe;
    logic [7:0] dbus_in;
    logic [7:0] dbus_out;
    logic       out_en;
    logic [7:0] pin_i, di_o, pu_o, dd_o, pv_o, die_o;
    logic       pud, sleep;
    logic [7:0] puoe, puov, ddoe, ddov, pvoe, pvov, dieoe, dieov;
    logic       pcie, pcint_ack, pcint_irq;

    int n_cmp = 0;
    int n_err = 0;

    always #5 cp2 = ~cp2;

    gpio_port_pcint #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .cp2(cp2), .ireset(ireset), .io_addr(io_addr), .iore(iore), .iowe(iowe),
        .dbus_in(dbus_in), .dbus_out(dbus_out), .out_en(out_en),
        .pin_i(pin_i), .di_o(di_o), .pu_o(pu_o), .dd_o(dd_o), .pv_o(pv_o), .die_o(die_o),
        .pud(pud), .sleep(sleep),
        .puoe(puoe), .puov(puov), .ddoe(ddoe), .ddov(ddov),
        .pvoe(pvoe), .pvov(pvov), .dieoe(dieoe), .dieov(dieov),
        .pcie(pcie), .pcint_ack(pcint_ack), .pcint_irq(pcint_irq)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge cp2);
            #1;
        end
    endtask

    task automatic io_write(input logic [5:0] a, input logic [7:0] d);
        io_addr = a;
        dbus_in = d;
        iowe    = 1'b1;
        tick(1);
        iowe    = 1'b0;
        io_addr = 6'h00;
        dbus_in = 8'h00;
    endtask

    task automatic io_read(input string tag, input logic [5:0] a, input logic [7:0] exp);
        io_addr = a;
        iore    = 1'b1;
        #1;
        check(tag, dbus_out, exp);
        check({tag, "_oe"}, {7'd0, out_en}, 8'h01);
        iore    = 1'b0;
        io_addr = 6'h00;
    endtask

    initial begin
        ireset = 1'b1; io_addr = '0; iore = 0; iowe = 0; dbus_in = '0;
        pin_i = '0; pud = 0; sleep = 0;
        puoe = '0; puov = '0; ddoe = '0; ddov = '0;
        pvoe = '0; pvov = '0; dieoe = '0; dieov = '0;
        pcie = 0; pcint_ack = 0;
        tick(2);
        ireset = 1'b0;

        // Reset state
        check("rst_dbus", dbus_out, 8'h00);
        check("rst_oe", {7'd0, out_en}, 8'h00);
        check("rst_di", di_o, 8'h00);
        check("rst_dd", dd_o, 8'h00);
        check("rst_pv", pv_o, 8'h00);
        check("rst_pu", pu_o, 8'h00);
        check("rst_die", die_o, 8'hFF);
        check("rst_irq", {7'd0, pcint_irq}, 8'h00);

        // DDR/PORT to pads, pull-up and global disable
        io_write(A_DDR, 8'hF0);
        io_write(A_PORT, 8'hCC);
        check("dd_f0", dd_o, 8'hF0);
        check("pv_cc", pv_o, 8'hCC);
        check("pu_0c", pu_o, 8'h0C);
        pud = 1'b1; #1;
        check("pu_pud", pu_o, 8'h00);
        pud = 1'b0;
        io_read("rd_ddr", A_DDR, 8'hF0);
        io_addr = 6'h10; iore = 1'b1; #1;
        check("rd_unmap", dbus_out, 8'h00);
        check("rd_unmap_oe", {7'd0, out_en}, 8'h00);
        iore = 1'b0; io_addr = 6'h00;

        // PIN write toggles PORT
        io_write(A_PORT, 8'h0F);
        io_write(A_PIN, 8'h33);
        io_read("rd_port_tgl", A_PORT, 8'h3C);
        check("pv_3c", pv_o, 8'h3C);

        // Synchronizer latency and sleep gating
        pin_i = 8'h81;
        tick(1);
        check("di_lat1", di_o, 8'h00);
        tick(1);
        check("di_lat2", di_o, 8'h81);
        sleep = 1'b1; #1;
        check("di_sleep", di_o, 8'h00);
        check("die_sleep", die_o, 8'h00);
        io_read("rd_pin_sleep", A_PIN, 8'h00);
        sleep = 1'b0; #1;
        io_read("rd_pin", A_PIN, 8'h81);
        pin_i = 8'h00;
        tick(3);

        // Pin-change mask, flag latency, ack
        io_write(A_PCMSK, 8'h01);
        pcie = 1'b1;
        pin_i = 8'h02;
        tick(4);
        check("irq_masked", {7'd0, pcint_irq}, 8'h00);
        pin_i = 8'h03;
        tick(2);
        check("irq_cyc2", {7'd0, pcint_irq}, 8'h00);
        tick(1);
        check("irq_cyc3", {7'd0, pcint_irq}, 8'h01);
        io_read("rd_pcif", A_PCIF, 8'h01);
        io_write(A_PCIF, 8'h00);
        check("pcif_wr0", {7'd0, pcint_irq}, 8'h01);
        pcint_ack = 1'b1;
        tick(1);
        pcint_ack = 1'b0;
        check("irq_ack", {7'd0, pcint_irq}, 8'h00);

        // Set beats PCIF write-1 in the same cycle
        pin_i = 8'h02;
        tick(2);
        io_write(A_PCIF, 8'h01);
        check("set_vs_wr1", {7'd0, pcint_irq}, 8'h01);
        io_write(A_PCIF, 8'h01);
        check("pcif_wr1", {7'd0, pcint_irq}, 8'h00);

        // Set beats ack in the same cycle
        pin_i = 8'h03;
        tick(2);
        pcint_ack = 1'b1;
        tick(1);
        pcint_ack = 1'b0;
        check("set_vs_ack", {7'd0, pcint_irq}, 8'h01);
        io_write(A_PCIF, 8'h01);

        // Flag latches with pcie=0
        pcie = 1'b0;
        pin_i = 8'h02;
        tick(3);
        check("irq_pcie0", {7'd0, pcint_irq}, 8'h00);
        io_read("rd_pcif_pcie0", A_PCIF, 8'h01);
        pcie = 1'b1; #1;
        check("irq_pcie1", {7'd0, pcint_irq}, 8'h01);
        io_write(A_PCIF, 8'h01);

        // Mid-operation reset, pins held high through warm-up
        pin_i = 8'hFF;
        ireset = 1'b1;
        tick(1);
        check("rst2_dd", dd_o, 8'h00);
        check("rst2_irq", {7'd0, pcint_irq}, 8'h00);
        tick(1);
        ireset = 1'b0;
        io_write(A_PCMSK, 8'hFF);
        tick(5);
        check("warm_irq", {7'd0, pcint_irq}, 8'h00);
        io_read("warm_pcif", A_PCIF, 8'h00);
        pin_i = 8'h7F;
        tick(3);
        check("armed_irq", {7'd0, pcint_irq}, 8'h01);

        // Overrides win over registers and sleep
        io_write(A_DDR, 8'h55);
        io_write(A_PORT, 8'h33);
        sleep = 1'b1;
        ddoe = 8'hFF; pvoe = 8'hFF; puoe = 8'hFF; dieoe = 8'hFF;
        ddov = 8'hAA; pvov = 8'hAA; puov = 8'hAA; dieov = 8'hAA;
        #1;
        check("ovr_dd", dd_o, 8'hAA);
        check("ovr_pv", pv_o, 8'hAA);
        check("ovr_pu", pu_o, 8'hAA);
        check("ovr_die", die_o, 8'hAA);
        check("ovr_di", di_o, 8'h2A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
